// File: rtl/univ_ff_arbiter.sv
// rtl/univ_ff_arbiter.sv - two-requester round-robin arbiter driving a shared D/T/JK/SR register
// Commands are latched on handshake and applied one cycle later; done reports the result.
module univ_ff_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_mode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_mode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             done_id,
  output logic             err,
  output logic [7:0]       cmd_count
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             err_q, err_d;
  logic [7:0]       cmd_count_q, cmd_count_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] next_q;

  // Requester 1 wins when alone, or when contending and requester 0 was granted last.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    grant0     = req0_valid && !grant1;
    req0_ready = !reset && (state_q == IDLE) && grant0;
    req1_ready = !reset && (state_q == IDLE) && grant1;
  end

  always_comb begin
    next_q = q_q;
    unique case (mode_q)
      MODE_D:  next_q = a_q;
      MODE_T:  next_q = q_q ^ a_q;
      MODE_JK: next_q = (a_q & ~q_q) | (~b_q & q_q);
      MODE_SR: next_q = (a_q & ~b_q) | (q_q & ~(a_q ^ b_q));
      default: next_q = q_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    q_d          = q_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    err_d        = 1'b0;
    cmd_count_d  = cmd_count_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          mode_d       = grant1 ? req1_mode : req0_mode;
          a_d          = grant1 ? req1_a    : req0_a;
          b_d          = grant1 ? req1_b    : req0_b;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        q_d         = next_q;
        done_d      = 1'b1;
        done_id_d   = id_q;
        err_d       = (mode_q == MODE_SR) && ((a_q & b_q) != '0);
        cmd_count_d = cmd_count_q + 8'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mode_q       <= MODE_D;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      q_q          <= '0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      err_q        <= 1'b0;
      cmd_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      q_q          <= q_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      err_q        <= err_d;
      cmd_count_q  <= cmd_count_d;
    end
  end

  assign q         = q_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign err       = err_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_univ_ff_arbiter.sv
// tb/tb_univ_ff_arbiter.sv - randomized bench for univ_ff_arbiter against a transaction-level model
module tb_univ_ff_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_mode, req1_mode;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] q;
  logic       done, done_id, err;
  logic [7:0] cmd_count;

  univ_ff_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b),
    .q(q), .done(done), .done_id(done_id), .err(err), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester-side pending commands
  bit         cur_v[2];
  logic [1:0] cur_m[2];
  logic [7:0] cur_a[2], cur_b[2];

  // Reference model: register value, completion count, round-robin memory, one in-flight command
  logic [7:0] m_q;
  int         m_count;
  int         m_last;
  bit         p_valid;
  int         p_due, p_id;
  logic [1:0] p_mode;
  logic [7:0] p_a, p_b;
  int         cyc = 0;
  int         n_done = 0;
  int         n_grants = 0;
  int         grants[$];

  function automatic logic [7:0] ref_next(logic [7:0] cur, logic [1:0] m, logic [7:0] a, logic [7:0] b);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'd0: n[i] = a[i];
        2'd1: n[i] = cur[i] ^ a[i];
        2'd2: case ({a[i], b[i]})
                2'b00:   n[i] = cur[i];
                2'b01:   n[i] = 1'b0;
                2'b10:   n[i] = 1'b1;
                default: n[i] = ~cur[i];
              endcase
        default: case ({a[i], b[i]})
                2'b01:   n[i] = 1'b0;
                2'b10:   n[i] = 1'b1;
                default: n[i] = cur[i];
              endcase
      endcase
    end
    return n;
  endfunction

  task automatic drive();
    req0_valid = cur_v[0];
    req0_mode  = cur_v[0] ? cur_m[0] : 2'($urandom);
    req0_a     = cur_v[0] ? cur_a[0] : 8'($urandom);
    req0_b     = cur_v[0] ? cur_b[0] : 8'($urandom);
    req1_valid = cur_v[1];
    req1_mode  = cur_v[1] ? cur_m[1] : 2'($urandom);
    req1_a     = cur_v[1] ? cur_a[1] : 8'($urandom);
    req1_b     = cur_v[1] ? cur_b[1] : 8'($urandom);
  endtask

  task automatic settle();
    bit free, any;
    int w;
    #1;
    free = !reset && !p_valid;
    any  = cur_v[0] || cur_v[1];
    if (cur_v[0] && cur_v[1]) w = 1 - m_last;
    else                      w = cur_v[1] ? 1 : 0;
    check("ready0", req0_ready, free && any && (w == 0));
    check("ready1", req1_ready, free && any && (w == 1));
    if (free && any) begin
      p_valid = 1'b1;
      p_due   = cyc + 2;
      p_id    = w;
      p_mode  = cur_m[w];
      p_a     = cur_a[w];
      p_b     = cur_b[w];
      m_last  = w;
      grants.push_back(w);
      n_grants++;
      cur_v[w] = 1'b0;
    end
  endtask

  task automatic tick();
    bit exp_done;
    @(posedge clk);
    cyc++;
    #1;
    exp_done = 1'b0;
    if (reset) begin
      m_q = 8'h00; m_count = 0; m_last = 1; p_valid = 1'b0;
    end else if (p_valid && p_due == cyc) begin
      exp_done = 1'b1;
      m_q      = ref_next(m_q, p_mode, p_a, p_b);
      m_count  = (m_count + 1) % 256;
      p_valid  = 1'b0;
      n_done++;
    end
    check("done", done, exp_done);
    if (exp_done) begin
      check("done_id", done_id, p_id);
      check("err", err, (p_mode == 2'd3) && ((p_a & p_b) != 8'h00));
    end else begin
      check("err_idle", err, 1'b0);
    end
    check("q", q, m_q);
    check("cmd_count", cmd_count, m_count);
  endtask

  task automatic cycle();
    drive();
    settle();
    tick();
  endtask

  task automatic send(input int id, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    cur_v[id] = 1'b1; cur_m[id] = m; cur_a[id] = a; cur_b[id] = b;
    for (int k = 0; k < 10 && cur_v[id]; k++) cycle();
    check("send_timeout", cur_v[id], 1'b0);
    cur_v[id] = 1'b0;
    cycle();
  endtask

  task automatic rand_cmd(input int id);
    cur_v[id] = 1'b1;
    cur_m[id] = 2'($urandom);
    cur_a[id] = 8'($urandom);
    cur_b[id] = 8'($urandom);
  endtask

  initial begin
    m_q = 8'h00; m_count = 0; m_last = 1; p_valid = 1'b0;
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;

    // Reset with both requesters asserting valid: ready must stay low
    reset = 1'b1;
    rand_cmd(0); rand_cmd(1);
    cycle(); cycle();
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;
    check("rst_q", q, 8'h00);
    check("rst_count", cmd_count, 8'd0);
    check("rst_done_id", done_id, 1'b0);
    reset = 1'b0;
    cycle();

    send(0, 2'd0, 8'hA5, 8'h00);
    check("s1_q", q, 8'hA5);
    check("s1_done", done, 1'b1);
    check("s1_id", done_id, 1'b0);
    check("s1_count", cmd_count, 8'd1);

    send(1, 2'd1, 8'hFF, 8'h00);
    check("s2_q", q, 8'h5A);
    check("s2_id", done_id, 1'b1);

    send(0, 2'd0, 8'h0F, 8'h00);
    send(0, 2'd2, 8'hF0, 8'h3C);
    check("s3_jk", q, 8'hF3);

    send(0, 2'd0, 8'h0F, 8'h00);
    send(1, 2'd3, 8'h11, 8'h11);
    check("s4_sr", q, 8'h0F);
    check("s4_err", err, 1'b1);

    // Contention from a fresh reset: expect 0,1,0,1
    reset = 1'b1; cycle(); reset = 1'b0;
    grants.delete();
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      if (!cur_v[0]) rand_cmd(0);
      if (!cur_v[1]) rand_cmd(1);
      cycle();
    end
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;
    repeat (3) cycle();
    check("rr_len", grants.size(), 4);
    if (grants.size() >= 4) begin
      check("rr_g0", grants[0], 0);
      check("rr_g1", grants[1], 1);
      check("rr_g2", grants[2], 0);
      check("rr_g3", grants[3], 1);
    end

    // Reset during EXEC drops the in-flight command
    reset = 1'b1; cycle(); reset = 1'b0;
    cur_v[0] = 1'b1; cur_m[0] = 2'd0; cur_a[0] = 8'h77; cur_b[0] = 8'h00;
    for (int k = 0; k < 10 && cur_v[0]; k++) cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    cycle(); cycle();
    check("rx_q", q, 8'h00);
    check("rx_done", done, 1'b0);
    check("rx_count", cmd_count, 8'd0);

    // Random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      for (int r = 0; r < 2; r++)
        if (!cur_v[r] && ($urandom % 3 == 0)) rand_cmd(r);
      reset = ($urandom % 97 == 0);
      cycle();
    end
    reset = 1'b0;
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;

    // 256 commands wrap cmd_count to 0
    reset = 1'b1; cycle(); reset = 1'b0;
    n_grants = 0; n_done = 0;
    for (int k = 0; k < 2000 && n_grants < 256; k++) begin
      for (int r = 0; r < 2; r++)
        if (!cur_v[r] && ($urandom % 2 == 0)) rand_cmd(r);
      cycle();
      if (n_grants >= 256) begin
        cur_v[0] = 1'b0; cur_v[1] = 1'b0;
      end
    end
    repeat (3) cycle();
    check("wrap_done", n_done, 256);
    check("wrap_count", cmd_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
